// File: rtl/irq_seq_pkg.sv
// rtl/irq_seq_pkg.sv - shared constants for the interrupt sequencer: config map, FSM codes, STATUS fields
package irq_seq_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] CFG_MASK   = 2'd0;
    localparam logic [1:0] CFG_PEND   = 2'd1;
    localparam logic [1:0] CFG_STATUS = 2'd2;
    localparam logic [1:0] CFG_TIMER  = 2'd3;

    localparam fsm_state_t S_IDLE    = 2'd0;
    localparam fsm_state_t S_TAKE    = 2'd1;
    localparam fsm_state_t S_SERVICE = 2'd2;

    localparam int ST_GIE   = 0;
    localparam int ST_INSVC = 1;
    localparam int ST_ID_LO = 4;
    localparam int ST_ID_HI = 7;

endpackage

// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - CPU config register port of the interrupt sequencer
interface irq_sequencer_if;

    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wd;
    logic [31:0] cfg_rd;

    modport master (output cfg_we, output cfg_addr, output cfg_wd, input cfg_rd);
    modport slave  (input cfg_we, input cfg_addr, input cfg_wd, output cfg_rd);

endinterface

// File: rtl/irq_sequencer_prio_enc.sv
// rtl/irq_sequencer_prio_enc.sv - lowest-set-bit priority encoder (bit 0 wins)
module prio_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   id_o
);

    assign valid_o = |req_i;

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        id_o = 4'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt sequencer for the MIPS datapath; optional timer source via IRQ_SEQ_TIMER_EN
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq_src,
    input  logic               ret,
    irq_sequencer_if.slave     cfg,
    output logic               irq,
    output logic [31:0]        eaddr,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic               in_service
);

`ifdef IRQ_SEQ_TIMER_EN
    localparam int NI = N_IRQ + 1;
`else
    localparam int NI = N_IRQ;
`endif

    fsm_state_t        state_q, state_d;
    logic [N_IRQ-1:0]  src_q;
    logic [NI-1:0]     pend_q, pend_d;
    logic [NI-1:0]     mask_q, mask_d;
    logic              gie_q, gie_d;
    logic [3:0]        active_id_q, active_id_d;
    logic [31:0]       eaddr_q, eaddr_d;

    logic [NI-1:0]     eligible, edges, take_clr, w1c_clr, tmr_set;
    logic              win_valid;
    logic [3:0]        win_id;
    logic [31:0]       timer_rd, rd_v;
    logic              wr_mask, wr_pend, wr_status, wr_timer;

    assign wr_mask   = cfg.cfg_we && (cfg.cfg_addr == CFG_MASK);
    assign wr_pend   = cfg.cfg_we && (cfg.cfg_addr == CFG_PEND);
    assign wr_status = cfg.cfg_we && (cfg.cfg_addr == CFG_STATUS);
    assign wr_timer  = cfg.cfg_we && (cfg.cfg_addr == CFG_TIMER);

`ifdef IRQ_SEQ_TIMER_EN
    logic [31:0] period_q, period_d, count_q, count_d;
    logic        tmr_hit;

    assign tmr_hit = (period_q != 32'd0) && (count_q == 32'd1);

    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        if (wr_timer) begin
            period_d = cfg.cfg_wd;
            count_d  = cfg.cfg_wd;
        end else if (tmr_hit) begin
            count_d = period_q;
        end else if ((period_q != 32'd0) && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

    assign tmr_set  = {tmr_hit, {N_IRQ{1'b0}}};
    assign timer_rd = count_q;
`else
    logic unused_cfg;

    assign unused_cfg = wr_timer ^ (^cfg.cfg_wd[31:NI]);
    assign tmr_set    = '0;
    assign timer_rd   = 32'd0;
`endif

    assign edges    = NI'(irq_src & ~src_q);
    assign eligible = pend_q & mask_q;
    assign take_clr = (state_q == S_TAKE) ? (NI'(1) << active_id_q) : '0;
    assign w1c_clr  = wr_pend ? cfg.cfg_wd[NI-1:0] : '0;

    prio_enc #(.W(NI)) u_prio (
        .req_i   (eligible),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // A fresh edge is OR-ed in after the clears so it survives a same-cycle clear.
    always_comb begin
        pend_d = (pend_q & ~(take_clr | w1c_clr)) | edges | tmr_set;
        mask_d = wr_mask ? cfg.cfg_wd[NI-1:0] : mask_q;
        gie_d  = wr_status ? cfg.cfg_wd[ST_GIE] : gie_q;
    end

    // Winner id and vector are captured on TAKE entry so later edges cannot disturb the pulse.
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        eaddr_d     = eaddr_q;
        case (state_q)
            S_IDLE: begin
                if (gie_q && win_valid && !ret) begin
                    state_d     = S_TAKE;
                    active_id_d = win_id;
                    eaddr_d     = VEC_BASE + 32'(win_id) * VEC_STRIDE;
                end
            end
            S_TAKE:    state_d = S_SERVICE;
            S_SERVICE: if (ret) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            gie_q       <= 1'b0;
            active_id_q <= 4'd0;
            eaddr_q     <= VEC_BASE;
        end else begin
            state_q     <= state_d;
            src_q       <= irq_src;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            gie_q       <= gie_d;
            active_id_q <= active_id_d;
            eaddr_q     <= eaddr_d;
        end
    end

    assign irq        = (state_q == S_TAKE);
    assign irq_ack    = take_clr[N_IRQ-1:0];
    assign eaddr      = eaddr_q;
    assign in_service = (state_q == S_SERVICE);

    always_comb begin
        rd_v = 32'd0;
        case (cfg.cfg_addr)
            CFG_MASK:   rd_v[NI-1:0] = mask_q;
            CFG_PEND:   rd_v[NI-1:0] = pend_q;
            CFG_STATUS: begin
                rd_v[ST_GIE]            = gie_q;
                rd_v[ST_INSVC]          = in_service;
                rd_v[ST_ID_HI:ST_ID_LO] = active_id_q;
            end
            default:    rd_v = timer_rd;
        endcase
    end

    assign cfg.cfg_rd = rd_v;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - scoreboard bench for irq_sequencer: directed vectors, monitor checks each irq pulse
module tb_irq_sequencer;
    import irq_seq_pkg::*;

    localparam int N_IRQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_IRQ-1:0]  irq_src = '0;
    logic              ret = 1'b0;
    logic              irq;
    logic [31:0]       eaddr;
    logic [N_IRQ-1:0]  irq_ack;
    logic              in_service;

    irq_sequencer_if cfg_bus ();

    irq_sequencer #(
        .N_IRQ      (N_IRQ),
        .VEC_BASE   (32'h0000_0180),
        .VEC_STRIDE (32'h0000_0020)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .ret        (ret),
        .cfg        (cfg_bus),
        .irq        (irq),
        .eaddr      (eaddr),
        .irq_ack    (irq_ack),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      ea;
        logic [N_IRQ-1:0] ack;
        int               at;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_irq(input logic [31:0] ea, input logic [N_IRQ-1:0] ack, input int dly);
        sb.push_back('{ea: ea, ack: ack, at: cyc + dly});
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_addr = addr;
        cfg_bus.cfg_wd   = data;
        tick();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        cfg_bus.cfg_addr = addr;
        #1;
        check(name, cfg_bus.cfg_rd, exp);
    endtask

    // Monitor: every irq pulse must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (rst && irq === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_irq: got irq=1 eaddr=%h at cycle %0d expected no irq", eaddr, cyc);
            end else begin
                got = sb.pop_front();
                check("irq_eaddr", eaddr, got.ea);
                check("irq_ack", 32'(irq_ack), 32'(got.ack));
                check("irq_cycle", 32'(cyc), 32'(got.at));
            end
        end
    end

    initial begin
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_addr = 2'd0;
        cfg_bus.cfg_wd   = 32'd0;
        repeat (2) tick();

        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_eaddr", eaddr, 32'h180);
        check("rst_in_service", 32'(in_service), 32'd0);
        cfg_check("rst_mask", CFG_MASK, 32'd0);
        cfg_check("rst_pend", CFG_PEND, 32'd0);
        cfg_check("rst_status", CFG_STATUS, 32'd0);
        tick();
        cfg_check("rst_timer", CFG_TIMER, 32'd0);
        rst = 1'b1;
        tick();

        // single source, latency and vector
        cfg_write(CFG_STATUS, 32'h1);
        cfg_write(CFG_MASK, 32'hF);
        irq_src = 4'b0100;
        expect_irq(32'h1C0, 4'b0100, 2);
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        check("t1_in_service", 32'(in_service), 32'd1);
        check("t1_eaddr_hold", eaddr, 32'h1C0);
        cfg_check("t1_status", CFG_STATUS, 32'h23);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        check("t1_in_service_after_ret", 32'(in_service), 32'd0);

        // simultaneous sources, lowest index first, back-to-back after ret
        irq_src = 4'b1010;
        expect_irq(32'h1A0, 4'b0010, 2);
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        cfg_check("t2_pend", CFG_PEND, 32'h8);
        ret = 1'b1;
        expect_irq(32'h1E0, 4'b1000, 2);
        tick();
        ret = 1'b0;
        tick();
        tick();
        cfg_check("t2_status", CFG_STATUS, 32'h33);
        ret = 1'b1;
        tick();
        ret = 1'b0;

        // ret while IDLE blocks the take for that cycle only
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        ret = 1'b1;
        expect_irq(32'h180, 4'b0001, 2);
        tick();
        ret = 1'b0;
        tick();
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;

        // masked request stays pending until unmasked
        cfg_write(CFG_MASK, 32'h0);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        cfg_check("t3_pend_masked", CFG_PEND, 32'h1);
        expect_irq(32'h180, 4'b0001, 2);
        cfg_write(CFG_MASK, 32'h1);
        tick();
        tick();
        cfg_check("t3_pend_cleared", CFG_PEND, 32'h0);
        ret = 1'b1;
        tick();
        ret = 1'b0;

        // W1C racing a new edge
        cfg_write(CFG_MASK, 32'h0);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        cfg_check("t4_pend_set", CFG_PEND, 32'h1);
        irq_src = 4'b0001;
        cfg_write(CFG_PEND, 32'h1);
        irq_src = 4'b0000;
        cfg_check("t4_edge_wins", CFG_PEND, 32'h1);
        tick();
        cfg_write(CFG_PEND, 32'h1);
        cfg_check("t4_w1c", CFG_PEND, 32'h0);

        // optional timer source, or the unused TIMER slot
`ifdef IRQ_SEQ_TIMER_EN
        cfg_write(CFG_MASK, 32'h10);
        expect_irq(32'h200, 4'b0000, 7);
        cfg_write(CFG_TIMER, 32'd5);
        cfg_check("t6_timer_load", CFG_TIMER, 32'd5);
        repeat (7) tick();
        check("t6_in_service", 32'(in_service), 32'd1);
        ret = 1'b1;
        cfg_write(CFG_TIMER, 32'd0);
        ret = 1'b0;
        cfg_write(CFG_PEND, 32'h1F);
        cfg_check("t6_timer_stopped", CFG_TIMER, 32'd0);
        repeat (10) tick();
`else
        cfg_write(CFG_TIMER, 32'd5);
        cfg_check("t6_timer_absent", CFG_TIMER, 32'd0);
`endif

        // reset in the middle of service
        cfg_write(CFG_MASK, 32'hF);
        irq_src = 4'b0010;
        expect_irq(32'h1A0, 4'b0010, 2);
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        irq_src = 4'b1000;
        tick();
        irq_src = 4'b0000;
        tick();
        cfg_check("t5_pend_before", CFG_PEND, 32'h8);
        check("t5_in_service_before", 32'(in_service), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_in_service", 32'(in_service), 32'd0);
        check("t5_eaddr", eaddr, 32'h180);
        cfg_check("t5_pend", CFG_PEND, 32'h0);
        tick();
        cfg_check("t5_mask", CFG_MASK, 32'h0);
        cfg_check("t5_status", CFG_STATUS, 32'h0);
        tick();
        rst = 1'b1;
        repeat (8) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
